// File: rtl/pipelined_adder_arbiter.sv
// pipelined_adder_arbiter: round-robin sharing of an external pipelined adder with latency-matched result routing
module pipelined_adder_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 3,
  parameter int LATENCY = 4,
  parameter int ID_W    = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*WIDTH-1:0]         req_a,
  input  logic [NUM_REQ*WIDTH-1:0]         req_b,
  input  logic [NUM_REQ-1:0]               req_cin,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [WIDTH-1:0]                 add_a,
  output logic [WIDTH-1:0]                 add_b,
  output logic                             add_cin,
  input  logic [WIDTH-1:0]                 add_s,
  input  logic                             add_c,
  output logic                             rsp_valid,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [WIDTH-1:0]                 rsp_sum,
  output logic                             rsp_cout,
  output logic [$clog2(LATENCY+1)-1:0]     inflight,
  output logic                             idle
);
  localparam int CW = $clog2(LATENCY + 1);
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic               issue;
  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [LATENCY];
  int                 k;
  // Search from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    k = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      k = (int'(ptr) + j) % NUM_REQ;
      if (en && req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        gnt_id = ID_W'(k);
      end
    end
  end
  assign issue     = |gnt;
  assign add_a     = issue ? req_a[int'(gnt_id)*WIDTH +: WIDTH] : '0;
  assign add_b     = issue ? req_b[int'(gnt_id)*WIDTH +: WIDTH] : '0;
  assign add_cin   = issue & req_cin[gnt_id];
  assign rsp_valid = tag_v[LATENCY-1];
  assign rsp_id    = tag_id[LATENCY-1];
  assign rsp_sum   = rsp_valid ? add_s : '0;
  assign rsp_cout  = rsp_valid & add_c;
  assign idle      = (inflight == '0) && !issue;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      tag_v <= '0;
      inflight <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
    end else begin
      if (issue) ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      tag_v <= {tag_v[LATENCY-2:0], issue};
      tag_id[0] <= gnt_id;
      for (int i = 1; i < LATENCY; i++) tag_id[i] <= tag_id[i-1];
      inflight <= inflight + CW'(issue) - CW'(rsp_valid);
    end
  end
endmodule
